// File: rtl/so3s_otfc_seq.sv
// so3s_otfc_seq -- on-the-fly converter from MSD-first signed-digit
// (redundant binary) input to two's complement output.
//
// Each lane keeps Q and QM = Q - 2^(N_DIGITS-j). These are updated only by
// OR-ing one bit or copying between the two registers, so there is no carry
// chain. All lanes share one FSM, one digit counter and one handshake.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           begin a conversion (IDLE, or DONE while out_ready=1)
//   flush           end the current conversion early; remaining digits are 0
//   in_valid/ready  digit beat handshake, x carries one digit per lane
//   out_valid/ready result handshake, q/qm hold per-lane Q and QM
//   busy            conversion in progress or result pending
//   err             sticky: a lane saw the illegal digit plus=minus=1
//   digit_cnt       number of digits consumed so far
package rbr_pkg;
  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;
endpackage

module so3s_otfc_seq #(
  parameter int N_DIGITS = 8,
  parameter int WIDTH    = 10,
  parameter int LANES    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  rbr_pkg::signed_digit [LANES-1:0]    x,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*WIDTH-1:0]              q,
  output logic [LANES*WIDTH-1:0]              qm,
  output logic                                busy,
  output logic                                err,
  output logic [$clog2(N_DIGITS+1)-1:0]       digit_cnt
);

  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << N_DIGITS) - 64'd1);
  // QM starts at -2^N_DIGITS: all bits above the digit field set.
  localparam logic signed [WIDTH-1:0] QM_INIT = ~LOW_MASK;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] qm;
    logic                    bad;
  } step_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] q_r   [LANES];
  logic signed [WIDTH-1:0] qm_r  [LANES];
  step_t                   nxt   [LANES];
  logic [CNT_W-1:0]        cnt_r;
  logic                    err_r;
  logic [WIDTH-1:0]        pos;
  logic                    start_acc;
  logic                    beat;
  logic                    last_beat;
  logic                    any_bad;

  // One conversion step for one lane. The illegal digit behaves as 0 and
  // raises the bad flag.
  function automatic step_t digit_step(
    input logic signed [WIDTH-1:0] q_c,
    input logic signed [WIDTH-1:0] qm_c,
    input rbr_pkg::signed_digit    d,
    input logic [WIDTH-1:0]        p
  );
    step_t r;
    r.bad = d.plus & d.minus;
    if (d.plus && !d.minus) begin
      r.q  = q_c | p;
      r.qm = q_c;
    end else if (!d.plus && d.minus) begin
      r.q  = qm_c | p;
      r.qm = qm_c;
    end else begin
      r.q  = q_c;
      r.qm = qm_c | p;
    end
    return r;
  endfunction

  assign start_acc = start && ((state == IDLE) || (state == DONE && out_ready));
  // A concurrent flush takes precedence over the beat.
  assign beat      = (state == CONV) && in_valid && !flush;
  assign last_beat = beat && (cnt_r == CNT_W'(N_DIGITS - 1));

  // One-hot weight 2^k of the digit being consumed, k = N_DIGITS-1-cnt.
  always_comb begin
    pos = '0;
    for (int b = 0; b < N_DIGITS; b++) begin
      if (cnt_r == CNT_W'(N_DIGITS - 1 - b)) pos[b] = 1'b1;
    end
  end

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      nxt[i]  = digit_step(q_r[i], qm_r[i], x[i], pos);
      any_bad = any_bad | nxt[i].bad;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CONV;
      CONV: if (flush || last_beat) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = start ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      CONV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: registers only move on start or an accepted beat, so the
  // result holds in DONE and IDLE without further gating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        q_r[i]  <= '0;
        qm_r[i] <= '0;
      end
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (start_acc) begin
      for (int i = 0; i < LANES; i++) begin
        q_r[i]  <= '0;
        qm_r[i] <= QM_INIT;
      end
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (beat) begin
      for (int i = 0; i < LANES; i++) begin
        q_r[i]  <= nxt[i].q;
        qm_r[i] <= nxt[i].qm;
      end
      cnt_r <= cnt_r + CNT_W'(1);
      if (any_bad) err_r <= 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign q [g*WIDTH +: WIDTH] = q_r[g];
    assign qm[g*WIDTH +: WIDTH] = qm_r[g];
  end

  assign err       = err_r;
  assign digit_cnt = cnt_r;

endmodule

// File: tb/tb_so3s_otfc_seq.sv
// Directed bench for so3s_otfc_seq: a single-lane instance for the main
// sequences and a two-lane instance for lane independence and err.
module tb_so3s_otfc_seq;

  logic clk = 1'b0;
  logic rst;

  // single-lane instance
  logic                          start, flush, in_valid, out_ready;
  logic                          in_ready, out_valid, busy, err;
  rbr_pkg::signed_digit [0:0]    x1;
  logic [9:0]                    q1, qm1;
  logic [3:0]                    cnt1;

  // two-lane instance
  logic                          start2, flush2, in_valid2, out_ready2;
  logic                          in_ready2, out_valid2, busy2, err2;
  rbr_pkg::signed_digit [1:0]    x2;
  logic [19:0]                   q2, qm2;
  logic [3:0]                    cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  so3s_otfc_seq #(.N_DIGITS(8), .WIDTH(10), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .x(x1),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q1), .qm(qm1), .busy(busy), .err(err), .digit_cnt(cnt1)
  );

  so3s_otfc_seq #(.N_DIGITS(8), .WIDTH(10), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .x(x2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .q(q2), .qm(qm2), .busy(busy2), .err(err2), .digit_cnt(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic p, input logic m);
    in_valid    = 1'b1;
    x1[0].plus  = p;
    x1[0].minus = m;
    tick();
    in_valid = 1'b0;
    x1       = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; flush = 0; in_valid = 0; out_ready = 0; x1 = '0;
    start2 = 0; flush2 = 0; in_valid2 = 0; out_ready2 = 0; x2 = '0;
    tick(); tick();
    chk("rst_q",        32'(q1),        32'h0);
    chk("rst_qm",       32'(qm1),       32'h0);
    chk("rst_out_valid",32'(out_valid), 32'h0);
    chk("rst_busy",     32'(busy),      32'h0);
    chk("rst_in_ready", 32'(in_ready),  32'h0);
    chk("rst_cnt",      32'(cnt1),      32'h0);
    rst = 1'b0;
    tick();

    // +1 followed by seven zeros
    do_start();
    chk("init_in_ready", 32'(in_ready), 32'h1);
    chk("init_busy",     32'(busy),     32'h1);
    chk("init_q",        32'(q1),       32'h000);
    chk("init_qm",       32'(qm1),      32'h300);
    chk("init_cnt",      32'(cnt1),     32'h0);
    beat(1, 0);
    repeat (6) beat(0, 0);
    chk("p1_ovld_early", 32'(out_valid), 32'h0);
    chk("p1_cnt7",       32'(cnt1),      32'h7);
    beat(0, 0);
    chk("p1_ovld",     32'(out_valid), 32'h1);
    chk("p1_q",        32'(q1),        32'h080);
    chk("p1_qm",       32'(qm1),       32'h07F);
    chk("p1_cnt",      32'(cnt1),      32'h8);
    chk("p1_in_ready", 32'(in_ready),  32'h0);
    chk("p1_err",      32'(err),       32'h0);
    pop();
    chk("idle_busy",   32'(busy),      32'h0);
    chk("idle_ovld",   32'(out_valid), 32'h0);
    chk("idle_q_keep", 32'(q1),        32'h080);

    // eight -1 digits
    do_start();
    repeat (8) beat(0, 1);
    chk("m1_ovld", 32'(out_valid), 32'h1);
    chk("m1_q",    32'(q1),        32'h301);
    chk("m1_qm",   32'(qm1),       32'h300);
    pop();

    // +1, -1, six zeros
    do_start();
    beat(1, 0);
    beat(0, 1);
    repeat (6) beat(0, 0);
    chk("pm_q",  32'(q1),  32'h040);
    chk("pm_qm", 32'(qm1), 32'h03F);

    // hold the result with out_ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_q",    32'(q1),        32'h040);
      chk("hold_qm",   32'(qm1),       32'h03F);
      chk("hold_ovld", 32'(out_valid), 32'h1);
      chk("hold_cnt",  32'(cnt1),      32'h8);
    end
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("b2b_in_ready", 32'(in_ready),  32'h1);
    chk("b2b_ovld",     32'(out_valid), 32'h0);
    chk("b2b_q",        32'(q1),        32'h000);
    chk("b2b_qm",       32'(qm1),       32'h300);
    chk("b2b_cnt",      32'(cnt1),      32'h0);

    // +1,+1 then flush with a concurrent -1 beat; start during CONV ignored
    start = 1'b1;
    beat(1, 0);
    start = 1'b0;
    chk("conv_start_ign", 32'(cnt1), 32'h1);
    beat(1, 0);
    flush = 1'b1;
    beat(0, 1);
    flush = 1'b0;
    chk("fl_ovld", 32'(out_valid), 32'h1);
    chk("fl_q",    32'(q1),        32'h0C0);
    chk("fl_qm",   32'(qm1),       32'h080);
    chk("fl_cnt",  32'(cnt1),      32'h2);
    pop();
    chk("fl_idle", 32'(busy), 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_busy", 32'(busy),      32'h0);
    chk("idle_flush_ovld", 32'(out_valid), 32'h0);

    // reset mid-conversion
    do_start();
    repeat (4) beat(1, 0);
    chk("pre_rst_cnt", 32'(cnt1), 32'h4);
    rst = 1'b1;
    #1;
    chk("mrst_q",        32'(q1),        32'h0);
    chk("mrst_qm",       32'(qm1),       32'h0);
    chk("mrst_cnt",      32'(cnt1),      32'h0);
    chk("mrst_in_ready", 32'(in_ready),  32'h0);
    chk("mrst_busy",     32'(busy),      32'h0);
    chk("mrst_ovld",     32'(out_valid), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    do_start();
    chk("post_rst_qm", 32'(qm1), 32'h300);
    repeat (8) beat(1, 0);
    chk("post_rst_ovld", 32'(out_valid), 32'h1);
    chk("post_rst_q",    32'(q1),        32'h0FF);
    chk("post_rst_qm2",  32'(qm1),       32'h0FE);
    pop();

    // two lanes: lane0 all +1, lane1 illegal at digit 3, others 0
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid2      = 1'b1;
      x2[0].plus     = 1'b1;
      x2[0].minus    = 1'b0;
      x2[1].plus     = (i == 3);
      x2[1].minus    = (i == 3);
      tick();
      if (i == 2) chk("l2_err_before", 32'(err2), 32'h0);
      if (i == 3) chk("l2_err_set",    32'(err2), 32'h1);
    end
    in_valid2 = 1'b0;
    x2 = '0;
    chk("l2_ovld", 32'(out_valid2), 32'h1);
    chk("l2_q",    32'(q2),         32'h000FF);
    chk("l2_qm",   32'(qm2),        32'hFFCFE);
    chk("l2_err",  32'(err2),       32'h1);
    out_ready2 = 1'b1; start2 = 1'b1;
    tick();
    out_ready2 = 1'b0; start2 = 1'b0;
    chk("l2_err_clr",  32'(err2),      32'h0);
    chk("l2_restart",  32'(in_ready2), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/so3s_otfc_seq.md
SO3S_OTFC_SEQ -- requirements
Module: so3s_otfc_seq

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: signed digits per conversion, MSD first, minimum 2.
REQ-002 SHALL have parameter WIDTH, default 10: result width, two's complement; legal only if WIDTH >= N_DIGITS+1.
REQ-003 SHALL have parameter LANES, default 1: independent converters sharing one handshake.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1: begin a conversion; sampled only when the block may accept it (REQ-016).
REQ-007 SHALL have port flush, input, 1: terminate the current conversion early.
REQ-008 SHALL have port in_valid, input, 1: digit beat valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts a digit beat.
REQ-010 SHALL have port x, input, LANES x signed_digit (rbr_pkg): one digit per lane per beat.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port q, output, LANES*WIDTH: converted value Q per lane; lane i is bits [i*WIDTH +: WIDTH].
REQ-014 SHALL have port qm, output, LANES*WIDTH: QM = Q - 2^(N_DIGITS-j) per lane, where j is the number of digits consumed.
REQ-015 SHALL have ports busy (output, 1), err (output, 1, sticky illegal-digit flag) and digit_cnt (output, $clog2(N_DIGITS+1)).

Function
REQ-016 SHALL use a three-state FSM: IDLE, CONV and DONE; start is accepted in IDLE, or in DONE only in a cycle where out_ready=1.
REQ-017 On an accepted start, the FSM SHALL enter CONV next cycle with per-lane Q=0, QM = -2^N_DIGITS (bits WIDTH-1..N_DIGITS set, others clear), digit_cnt=0 and err=0.
REQ-018 in_ready SHALL be 1 only in CONV; a beat is accepted on the clock edge where in_valid and in_ready are both 1.
REQ-019 For an accepted beat with k = N_DIGITS-1-digit_cnt, each lane SHALL update as follows:
  - digit +1 (plus=1, minus=0): Q <= Q|2^k, QM <= Q.
  - digit -1 (plus=0, minus=1): Q <= QM|2^k, QM <= QM.
  - digit 0 (plus=minus): Q <= Q, QM <= QM|2^k.
REQ-020 Updates SHALL be carry-free (OR only, no adders); bits above N_DIGITS-1 change only by copying between Q and QM.
REQ-021 The digit plus=minus=1 SHALL be treated as digit 0 and set err, which holds until the next accepted start or reset.
REQ-022 digit_cnt SHALL increment on each accepted beat; the beat making digit_cnt=N_DIGITS SHALL move the FSM to DONE on the next edge.
REQ-023 flush=1 in CONV SHALL move the FSM to DONE next cycle with Q and QM unchanged (remaining digits equal 0), ignoring any concurrent beat; flush outside CONV SHALL be ignored.
REQ-024 out_valid SHALL be 1 exactly in DONE; q, qm, err and digit_cnt SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 In DONE with out_ready=1, the FSM SHALL go to CONV if start=1 (re-initialised per REQ-017), else to IDLE.
REQ-026 In IDLE, q and qm SHALL retain the last result; start while busy=1 (CONV) SHALL be ignored.
REQ-027 busy SHALL be 1 in CONV and DONE; result latency SHALL be N_DIGITS accepted beats plus 1 cycle to out_valid.
REQ-028 Lanes SHALL be fully independent except for the shared FSM, digit_cnt and handshake; err SHALL be the OR over all lanes.

Reset
REQ-029 While rst=1, the block SHALL asynchronously force IDLE, q=0, qm=0, digit_cnt=0, err=0, in_ready=0, out_valid=0 and busy=0.
REQ-030 A reset asserted mid-conversion SHALL abandon the conversion with no output; the first start after rst deasserts SHALL behave per REQ-017.

Verification (N_DIGITS=8, WIDTH=10, LANES=1 unless stated)
REQ-031 Bench SHALL drive start, then digits +1,0,0,0,0,0,0,0 -> out_valid one cycle after the 8th beat, q=0x080, qm=0x07F.
REQ-032 Bench SHALL drive eight -1 digits -> q=0x301 (-255), qm=0x300; then drive +1,-1,0x6 -> q=0x040, qm=0x03F.
REQ-033 Bench SHALL drive +1,+1, then flush with in_valid=1 -> DONE, q=0x0C0, digit_cnt=2, and the concurrent beat is not applied.
REQ-034 Bench SHALL hold out_ready=0 for 5 cycles in DONE (outputs stable), then drive out_ready=1 and start in the same cycle -> CONV next cycle with q=0 and qm=0x300.
REQ-035 Bench SHALL assert rst after 4 beats -> all outputs 0 immediately; a new conversion then completes correctly.
REQ-036 Bench SHALL drive LANES=2 with lane0 all +1, lane1 digit 3 illegal (rest 0) -> q0=0x0FF, q1=0x000, err=1; err is cleared by the next start.
